// File: rtl/kd_tree_ctrl.sv
// kd_tree_ctrl: control sequencer for one clustering iteration over a kd-tree
// of cluster PEs. Runs a fixed sort phase, fetches points one at a time from
// the point store, broadcasts each point, walks it down the tree using the
// addressed node's go_left decision and strobes inc at the reached leaf.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, n_points     begin an iteration of n_points points (sampled in IDLE)
//   pt_valid/pt_ready   point store handshake, pt_data carries the point
//   go_left             decision of the node currently on node_sel
//   pe_*                registered PE control strobes
//   point_out           registered broadcast point
//   node_sel, level     heap index (root = 1) and depth (root = 0) of the walk
//   pt_count            points completed this iteration
//   busy, done          not IDLE / one-cycle end-of-iteration pulse
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// SORT    | 2*TREE_DEPTH cycles alternating parent/child switch
// FETCH   | pt_ready high, waiting for pt_valid
// BCAST   | point broadcast to PEs, root addressed
// DESCEND | one cycle per level, follows go_left toward a leaf
// INC     | leaf accumulates, point counted
// DONE    | one-cycle done pulse

module kd_tree_ctrl #(
  parameter int DIM        = 3,
  parameter int DATA_RANGE = 255,
  parameter int MAX_N      = 1000,
  parameter int MAX_DEPTH  = 16,
  parameter int TREE_DEPTH = 3,
  localparam int DIM_SIZE     = $clog2(DATA_RANGE),
  localparam int COUNTER_SIZE = $clog2(MAX_N),
  localparam int DEPTH_SIZE   = $clog2(MAX_DEPTH),
  localparam int NODE_SIZE    = TREE_DEPTH,
  localparam int CENTER_SIZE  = DIM * DIM_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COUNTER_SIZE-1:0] n_points,
  input  logic                    pt_valid,
  input  logic [CENTER_SIZE-1:0]  pt_data,
  output logic                    pt_ready,
  input  logic                    go_left,
  output logic                    pe_en,
  output logic                    pe_receive_point,
  output logic                    pe_inc,
  output logic                    pe_next_level,
  output logic                    pe_sorting,
  output logic                    pe_parent_switch,
  output logic                    pe_child_switch,
  output logic [CENTER_SIZE-1:0]  point_out,
  output logic [NODE_SIZE-1:0]    node_sel,
  output logic [DEPTH_SIZE-1:0]   level,
  output logic [COUNTER_SIZE-1:0] pt_count,
  output logic                    busy,
  output logic                    done
);

  localparam int SORT_W = $clog2(2 * MAX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SORT, S_FETCH, S_BCAST, S_DESCEND, S_INC, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SORT_W-1:0]       sort_cnt_q, sort_cnt_d;
  logic [COUNTER_SIZE-1:0] pt_count_q, pt_count_d;
  logic [COUNTER_SIZE-1:0] n_points_q, n_points_d;
  logic [CENTER_SIZE-1:0]  point_q, point_d;
  logic [NODE_SIZE-1:0]    node_sel_q, node_sel_d;
  logic [DEPTH_SIZE-1:0]   level_q, level_d;
  logic pt_ready_q, pt_ready_d;
  logic busy_q, busy_d;
  logic recv_q, recv_d;
  logic inc_q, inc_d;
  logic next_lvl_q, next_lvl_d;
  logic sorting_q, sorting_d;
  logic parent_q, parent_d;
  logic child_q, child_d;
  logic done_q, done_d;

  always_comb begin
    state_d    = state_q;
    sort_cnt_d = sort_cnt_q;
    pt_count_d = pt_count_q;
    n_points_d = n_points_q;
    point_d    = point_q;
    node_sel_d = node_sel_q;
    level_d    = level_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SORT;
          sort_cnt_d = SORT_W'(2 * TREE_DEPTH - 1);
          pt_count_d = '0;
          n_points_d = n_points;
        end
      end
      S_SORT: begin
        if (sort_cnt_q == '0) begin
          state_d = (n_points_q == '0) ? S_DONE : S_FETCH;
        end else begin
          sort_cnt_d = sort_cnt_q - SORT_W'(1);
        end
      end
      S_FETCH: begin
        if (pt_valid && pt_ready_q) begin
          point_d    = pt_data;
          node_sel_d = NODE_SIZE'(1);
          level_d    = '0;
          state_d    = S_BCAST;
        end
      end
      S_BCAST: begin
        state_d = (TREE_DEPTH == 1) ? S_INC : S_DESCEND;
      end
      S_DESCEND: begin
        // Left child is 2n, right child is 2n+1.
        node_sel_d = (node_sel_q << 1) | NODE_SIZE'(!go_left);
        level_d    = level_q + DEPTH_SIZE'(1);
        if (level_q == DEPTH_SIZE'(TREE_DEPTH - 2)) begin
          state_d = S_INC;
        end
      end
      S_INC: begin
        pt_count_d = pt_count_q + COUNTER_SIZE'(1);
        node_sel_d = '0;
        level_d    = '0;
        state_d    = (pt_count_d == n_points_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they are registered and
    // line up with the cycle the FSM spends in that state.
    busy_d     = (state_d != S_IDLE);
    pt_ready_d = (state_d == S_FETCH);
    recv_d     = (state_d == S_BCAST);
    next_lvl_d = (state_d == S_DESCEND);
    inc_d      = (state_d == S_INC);
    done_d     = (state_d == S_DONE);
    sorting_d  = (state_d == S_SORT);
    // The sort counter starts odd and counts down, so odd count = even cycle.
    parent_d   = (state_d == S_SORT) && sort_cnt_d[0];
    child_d    = (state_d == S_SORT) && !sort_cnt_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sort_cnt_q <= '0;
      pt_count_q <= '0;
      n_points_q <= '0;
      point_q    <= '0;
      node_sel_q <= '0;
      level_q    <= '0;
      pt_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      recv_q     <= 1'b0;
      inc_q      <= 1'b0;
      next_lvl_q <= 1'b0;
      sorting_q  <= 1'b0;
      parent_q   <= 1'b0;
      child_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sort_cnt_q <= sort_cnt_d;
      pt_count_q <= pt_count_d;
      n_points_q <= n_points_d;
      point_q    <= point_d;
      node_sel_q <= node_sel_d;
      level_q    <= level_d;
      pt_ready_q <= pt_ready_d;
      busy_q     <= busy_d;
      recv_q     <= recv_d;
      inc_q      <= inc_d;
      next_lvl_q <= next_lvl_d;
      sorting_q  <= sorting_d;
      parent_q   <= parent_d;
      child_q    <= child_d;
      done_q     <= done_d;
    end
  end

  assign pt_ready         = pt_ready_q;
  assign pe_en            = busy_q;
  assign busy             = busy_q;
  assign pe_receive_point = recv_q;
  assign pe_inc           = inc_q;
  assign pe_next_level    = next_lvl_q;
  assign pe_sorting       = sorting_q;
  assign pe_parent_switch = parent_q;
  assign pe_child_switch  = child_q;
  assign done             = done_q;
  assign point_out        = point_q;
  assign node_sel         = node_sel_q;
  assign level            = level_q;
  assign pt_count         = pt_count_q;

endmodule

// File: tb/tb_kd_tree_ctrl.sv
// Directed bench for kd_tree_ctrl with TREE_DEPTH = 3: sort phase, leaf paths,
// back-to-back streaming, stall with ignored start, and reset mid-walk.
module tb_kd_tree_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  n_points = '0;
  logic        pt_valid = 1'b0;
  logic [23:0] pt_data = '0;
  logic        go_left = 1'b0;
  logic        pt_ready, pe_en, pe_receive_point, pe_inc, pe_next_level;
  logic        pe_sorting, pe_parent_switch, pe_child_switch, busy, done;
  logic [23:0] point_out;
  logic [2:0]  node_sel;
  logic [3:0]  level;
  logic [9:0]  pt_count;

  int n_checks = 0;
  int n_fail = 0;

  kd_tree_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
    .go_left(go_left), .pe_en(pe_en), .pe_receive_point(pe_receive_point),
    .pe_inc(pe_inc), .pe_next_level(pe_next_level), .pe_sorting(pe_sorting),
    .pe_parent_switch(pe_parent_switch), .pe_child_switch(pe_child_switch),
    .point_out(point_out), .node_sel(node_sel), .level(level),
    .pt_count(pt_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {pt_ready, recv, inc, next_level, sorting, parent, child, done, busy, pe_en}
  localparam logic [9:0] E_IDLE  = 10'b0000000000;
  localparam logic [9:0] E_FETCH = 10'b1000000011;
  localparam logic [9:0] E_BCAST = 10'b0100000011;
  localparam logic [9:0] E_DESC  = 10'b0001000011;
  localparam logic [9:0] E_INC   = 10'b0010000011;
  localparam logic [9:0] E_SORTP = 10'b0000110011;
  localparam logic [9:0] E_SORTC = 10'b0000101011;
  localparam logic [9:0] E_DONE  = 10'b0000000111;

  function automatic logic [9:0] strb();
    return {pt_ready, pe_receive_point, pe_inc, pe_next_level, pe_sorting,
            pe_parent_switch, pe_child_switch, done, busy, pe_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Call at a negedge with start low and FSM idle; returns at the negedge of
  // the first cycle after the sort phase.
  task automatic start_iter(input logic [9:0] n);
    start = 1'b1;
    n_points = n;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("sort%0d_strb", i), 32'(strb()), 32'((i % 2 == 0) ? E_SORTP : E_SORTC));
      tick();
    end
  endtask

  typedef struct {
    logic [23:0] data;
    logic [1:0]  gl;    // gl[0] used at the root, gl[1] at level 1
    logic [2:0]  leaf;
  } vec_t;

  vec_t tbl [4];

  // Call at the negedge of a FETCH cycle; returns at the negedge of INC.
  task automatic do_point(input vec_t v, input int exp_count, input bit hold);
    logic [2:0] mid;
    mid = v.gl[0] ? 3'd2 : 3'd3;
    chk("fetch_strb", 32'(strb()), 32'(E_FETCH));
    chk("fetch_count", 32'(pt_count), exp_count - 1);
    pt_valid = 1'b1;
    pt_data = v.data;
    tick();
    if (!hold) pt_valid = 1'b0;
    chk("bcast_strb", 32'(strb()), 32'(E_BCAST));
    chk("bcast_point", 32'(point_out), 32'(v.data));
    chk("bcast_node", 32'(node_sel), 32'd1);
    chk("bcast_level", 32'(level), 32'd0);
    tick();
    chk("desc0_strb", 32'(strb()), 32'(E_DESC));
    chk("desc0_node", 32'(node_sel), 32'd1);
    go_left = v.gl[0];
    tick();
    chk("desc1_strb", 32'(strb()), 32'(E_DESC));
    chk("desc1_node", 32'(node_sel), 32'(mid));
    chk("desc1_level", 32'(level), 32'd1);
    go_left = v.gl[1];
    tick();
    chk("inc_strb", 32'(strb()), 32'(E_INC));
    chk("inc_leaf", 32'(node_sel), 32'(v.leaf));
    go_left = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{data: {8'd30, 8'd20, 8'd10}, gl: 2'b11, leaf: 3'd4};
    tbl[1] = '{data: 24'hA5_5A_01,          gl: 2'b10, leaf: 3'd6};
    tbl[2] = '{data: 24'hFE_00_7F,          gl: 2'b00, leaf: 3'd7};
    tbl[3] = '{data: 24'h12_34_56,          gl: 2'b01, leaf: 3'd5};

    // Reset state
    repeat (3) tick();
    chk("rst_strb", 32'(strb()), 32'(E_IDLE));
    chk("rst_node", 32'(node_sel), 32'd0);
    chk("rst_count", 32'(pt_count), 32'd0);
    chk("rst_point", 32'(point_out), 32'd0);
    rst = 1'b0;
    tick();

    // Sort only, n_points = 0
    start_iter(10'd0);
    chk("n0_done", 32'(strb()), 32'(E_DONE));
    tick();
    chk("n0_idle", 32'(strb()), 32'(E_IDLE));
    chk("n0_count", 32'(pt_count), 32'd0);
    tick();

    // Single point, all left
    start_iter(10'd1);
    do_point(tbl[0], 1, 1'b0);
    tick();
    chk("p1_done", 32'(strb()), 32'(E_DONE));
    chk("p1_count", 32'(pt_count), 32'd1);
    chk("p1_node_clr", 32'(node_sel), 32'd0);
    tick();
    chk("p1_idle", 32'(strb()), 32'(E_IDLE));

    // Path coverage, pt_valid dropped between points
    start_iter(10'd3);
    for (int i = 1; i < 4; i++) begin
      do_point(tbl[i], i, 1'b0);
      tick();
    end
    chk("path_done", 32'(strb()), 32'(E_DONE));
    chk("path_count", 32'(pt_count), 32'd3);
    tick();

    // Back-to-back stream of 4 points, pt_valid held high
    start_iter(10'd4);
    for (int i = 0; i < 4; i++) begin
      do_point(tbl[i], i + 1, 1'b1);
      tick();
    end
    pt_valid = 1'b0;
    chk("b2b_done", 32'(strb()), 32'(E_DONE));
    chk("b2b_count", 32'(pt_count), 32'd4);
    tick();
    chk("b2b_idle", 32'(strb()), 32'(E_IDLE));
    chk("b2b_count_hold", 32'(pt_count), 32'd4);

    // Stall in FETCH with a start pulse while busy
    start_iter(10'd2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_strb", i), 32'(strb()), 32'(E_FETCH));
      chk($sformatf("stall%0d_count", i), 32'(pt_count), 32'd0);
      start = (i == 1);
      n_points = 10'd7;
      tick();
    end
    start = 1'b0;
    do_point(tbl[2], 1, 1'b0);
    tick();
    do_point(tbl[3], 2, 1'b0);
    tick();
    chk("stall_done", 32'(strb()), 32'(E_DONE));
    chk("stall_count", 32'(pt_count), 32'd2);
    tick();
    chk("stall_idle", 32'(strb()), 32'(E_IDLE));
    tick();

    // Reset in the middle of DESCEND
    start_iter(10'd1);
    pt_valid = 1'b1;
    pt_data = tbl[1].data;
    tick();
    pt_valid = 1'b0;
    tick();
    chk("mid_desc_strb", 32'(strb()), 32'(E_DESC));
    rst = 1'b1;
    tick();
    chk("mid_rst_strb", 32'(strb()), 32'(E_IDLE));
    chk("mid_rst_node", 32'(node_sel), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_count", 32'(pt_count), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", 32'(strb()), 32'(E_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kd_tree_ctrl.md
Name: kd_tree_ctrl

Overview:
- Sequencer that drives the control side of the kd-tree of cluster PEs for one clustering iteration.
- Runs a fixed sort phase, streams points from the point store one at a time, and broadcasts each point into the tree.
- Walks each point down the tree using the addressed node's go_left decision, then strobes inc at the reached leaf.
- Sits between the point memory (valid/ready source) and the PE array; the PE array decodes node_sel.

Parameters:
dim, 3, number of dimensions per point
data_range, 255, maximum coordinate value; dim_size = $clog2(data_range)
max_n, 1000, maximum points per iteration; counter_size = $clog2(max_n)
max_depth, 16, maximum tree depth; depth_size = $clog2(max_depth)
tree_depth, 3, built tree levels (1..max_depth); node_size = tree_depth; center_size = dim*dim_size

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one iteration (sampled in IDLE only)
n_points  in  counter_size  points in this iteration
pt_valid  in  1  point store has data
pt_data  in  center_size  point, dim 0 in LSBs
pt_ready  out  1  controller accepts pt_data
go_left  in  1  decision of node currently on node_sel
pe_en  out  1  PE enable
pe_receive_point  out  1  PEs latch point_out
pe_inc  out  1  leaf at node_sel accumulates
pe_next_level  out  1  level advance strobe
pe_sorting  out  1  sort phase active
pe_parent_switch  out  1  swap with parent (sort phase)
pe_child_switch  out  1  swap with child (sort phase)
point_out  out  center_size  registered broadcast point
node_sel  out  node_size  heap index of addressed node, root = 1
level  out  depth_size  current level, root = 0
pt_count  out  counter_size  points completed this iteration
busy  out  1  not IDLE
done  out  1  one-cycle pulse at iteration end

Behaviour:
- Reset: all outputs 0; node_sel = 0; FSM to IDLE; internal counters 0. Reset mid-operation aborts immediately: no further strobes, and pt_count is not preserved.
- Strobes are driven from FSM state and registered counters only; no combinational path from go_left to any strobe.
- pe_en = busy.
- IDLE: while start = 1, the next state is SORT; pt_count and the sort counter are cleared.
- SORT: lasts exactly 2*tree_depth cycles with pe_sorting = 1.
  - Even sort cycles (0, 2, ...): pe_parent_switch = 1.
  - Odd sort cycles: pe_child_switch = 1.
  - The two switch strobes are never high together.
  - After the last sort cycle: if n_points == 0, go to DONE; otherwise go to FETCH.
- FETCH: pt_ready = 1.
  - pt_valid low stalls indefinitely; all PE strobes stay 0.
  - On pt_valid && pt_ready: point_out <= pt_data and the FSM goes to BCAST. pt_ready is low in every other state.
- BCAST: one cycle with pe_receive_point = 1, node_sel = 1, level = 0.
  - If tree_depth == 1, go to INC; otherwise go to DESCEND.
- DESCEND: one cycle per level, tree_depth-1 cycles in total, each with pe_next_level = 1.
  - At each clock edge: node_sel <= 2*node_sel + (go_left ? 0 : 1), and level <= level + 1.
  - When level == tree_depth-2 at the edge, the next state is INC.
- INC: one cycle with pe_inc = 1; node_sel holds the leaf (range 2^(tree_depth-1) .. 2^tree_depth-1).
  - pt_count <= pt_count + 1.
  - If pt_count+1 == n_points, go to DONE; otherwise go to FETCH.
  - node_sel and level are cleared on leaving INC.
- DONE: done = 1 for one cycle, then IDLE. pt_count holds its value until the next start.
- Latency per point: FETCH accept → BCAST → DESCEND ×(tree_depth-1) → INC, which is tree_depth+2 cycles with pt_valid held high. With tree_depth = 3 this is 5 cycles per point.
- start while busy: ignored.
- n_points is sampled only in IDLE on start; changes during busy are ignored.
- n_points > max_n is outside the contract.
- pt_count arithmetic is counter_size wide with no wrap, since pt_count ≤ n_points ≤ max_n.

Test Plan:
- Reset check: assert rst mid-DESCEND with tree_depth = 3 → next cycle all strobes 0, busy = 0, node_sel = 0, pt_count = 0.
- Sort phase: start, n_points = 0 → 6 SORT cycles with parent/child strobes alternating P,C,P,C,P,C, then done pulses exactly once, with no pt_ready and no pe_inc.
- Single point, go_left = 1 on every level: pt_data = {8'd30, 8'd20, 8'd10} → point_out holds it in BCAST; node_sel goes 1 → 2 → 4; pe_inc with node_sel = 4; pt_count = 1; done.
- Path coverage: go_left sequence 0 then 1 → leaf node_sel = 6; go_left 0,0 → 7; go_left 1,0 → 5.
- Back-to-back stream: n_points = 4, pt_valid held high → pe_inc every 5 cycles, 4 pe_inc pulses total, done on the cycle after the 4th INC, pt_count = 4.
- Stall plus ignored start: drop pt_valid for 3 cycles in FETCH and pulse start while busy → no strobes during the stall, the iteration is not restarted, and the completed count is unchanged.
